// File: rtl/fpu_vec_shuf_pipe_if.sv
// -----------------------------------------------------------------------------
// fpu_vec_shuf_pipe_if
//
// Purpose : Bundles the operand, control and result signals of the FPU vector
//           shuffle stage so the upstream operand stage (master) and the
//           shuffle pipe (slave) connect through one port.
//
// Signals :
//   exHold    core-wide pipeline hold (1 = freeze all pipe registers)
//   opValid   a shuffle op is presented this cycle
//   opDoShuf  1: use shufCtl, 0: identity lane order
//   regValRs  source vector S, lane i = bits [32i+31:32i]
//   regValRt  source vector T, same lane layout
//   shufCtl   lane index for output lane i = shufCtl[2i+1:2i]
//   srcSel    per-output-lane source select (0 = S, 1 = T)
//   negMask   per-output-lane bit-31 flip (only honoured with the negate build)
//   regOut    registered shuffled result
//   outValid  regOut holds a result produced this cycle
//
// Modports: master = upstream driver / bench, slave = fpu_vec_shuf_pipe.
// -----------------------------------------------------------------------------
interface fpu_vec_shuf_pipe_if;
    logic         exHold;
    logic         opValid;
    logic         opDoShuf;
    logic [127:0] regValRs;
    logic [127:0] regValRt;
    logic [7:0]   shufCtl;
    logic [3:0]   srcSel;
    logic [3:0]   negMask;
    logic [127:0] regOut;
    logic         outValid;

    modport master (
        output exHold,
        output opValid,
        output opDoShuf,
        output regValRs,
        output regValRt,
        output shufCtl,
        output srcSel,
        output negMask,
        input  regOut,
        input  outValid
    );

    modport slave (
        input  exHold,
        input  opValid,
        input  opDoShuf,
        input  regValRs,
        input  regValRt,
        input  shufCtl,
        input  srcSel,
        input  negMask,
        output regOut,
        output outValid
    );
endinterface

// File: rtl/fpu_vec_shuf_pipe.sv
// -----------------------------------------------------------------------------
// fpu_vec_shuf_pipe
//
// Purpose : Two-stage, four-lane 128-bit vector shuffle for the FPU SIMD path.
//           Stage 1 captures both source vectors plus the effective lane-index
//           word, source selects and (optionally) the negate mask. Stage 2
//           builds every 32-bit output lane from any lane of either source and
//           registers the result for writeback/forwarding. Latency is two
//           unheld cycles, throughput one op per unheld cycle.
//
// Ports   :
//   clock   in   core clock, all state updates on the rising edge
//   reset   in   synchronous active-high reset, wins over exHold
//   bus     slave modport of fpu_vec_shuf_pipe_if (operands, control, result)
//
// Build option:
//   FPUVEC_SHUF_NEG_EN  when defined, output lane i has bit 31 inverted when
//                       the captured negMask[i] is 1. When undefined negMask
//                       is ignored and no register is kept for it.
// -----------------------------------------------------------------------------
module fpu_vec_shuf_pipe (
    input  logic                  clock,
    input  logic                  reset,
    fpu_vec_shuf_pipe_if.slave    bus
);

    localparam int          LANES    = 4;
    localparam int          LANE_W   = 32;
    localparam int          VEC_W    = LANES * LANE_W;
    // Identity lane order: output lane i reads source lane i.
    localparam logic [7:0]  IDX_IDENT = 8'b11_10_01_00;

    // Pick one 32-bit lane out of S or T.
    function automatic logic [LANE_W-1:0] f_lane_pick(
        input logic [VEC_W-1:0] s,
        input logic [VEC_W-1:0] t,
        input logic [1:0]       idx,
        input logic             sel
    );
        logic [VEC_W-1:0] src;
        src = sel ? t : s;
        return src[{idx, 5'b00000} +: LANE_W];
    endfunction

`ifdef FPUVEC_SHUF_NEG_EN
    // Only the sign bit is touched; the lane is never interpreted as FP.
    function automatic logic [LANE_W-1:0] f_sign_flip(
        input logic [LANE_W-1:0] lane,
        input logic              flip
    );
        return {lane[LANE_W-1] ^ flip, lane[LANE_W-2:0]};
    endfunction
`endif

    logic             w_adv;
    logic [7:0]       w_eff_idx_p0;

    logic             r_vld_p1;
    logic [VEC_W-1:0] r_s_p1;
    logic [VEC_W-1:0] r_t_p1;
    logic [7:0]       r_idx_p1;
    logic [3:0]       r_sel_p1;
`ifdef FPUVEC_SHUF_NEG_EN
    logic [3:0]       r_neg_p1;
`else
    logic             w_unused_neg;
`endif

    logic [VEC_W-1:0] w_res_p1;

    logic             r_vld_p2;
    logic [VEC_W-1:0] r_out_p2;

    assign w_adv        = ~bus.exHold;
    assign w_eff_idx_p0 = bus.opDoShuf ? bus.shufCtl : IDX_IDENT;

`ifndef FPUVEC_SHUF_NEG_EN
    // negMask is part of the shared bus but carries no meaning in this build.
    assign w_unused_neg = ^bus.negMask;
`endif

    // ---- stage 0 -> 1 : operand capture ----
    always_ff @(posedge clock) begin
        if (reset) begin
            r_vld_p1 <= 1'b0;
            r_s_p1   <= '0;
            r_t_p1   <= '0;
            r_idx_p1 <= '0;
            r_sel_p1 <= '0;
`ifdef FPUVEC_SHUF_NEG_EN
            r_neg_p1 <= '0;
`endif
        end else if (w_adv) begin
            r_vld_p1 <= bus.opValid;
            // Data registers only move on a real op so idle cycles cost no toggles.
            if (bus.opValid) begin
                r_s_p1   <= bus.regValRs;
                r_t_p1   <= bus.regValRt;
                r_idx_p1 <= w_eff_idx_p0;
                r_sel_p1 <= bus.srcSel;
`ifdef FPUVEC_SHUF_NEG_EN
                r_neg_p1 <= bus.negMask;
`endif
            end
        end
    end

    // Per-lane 4:1 lane mux plus source select; lanes are fully independent,
    // so duplicates and broadcasts fall out naturally.
    always_comb begin
        w_res_p1 = '0;
        for (int i = 0; i < LANES; i++) begin
`ifdef FPUVEC_SHUF_NEG_EN
            w_res_p1[i*LANE_W +: LANE_W] =
                f_sign_flip(f_lane_pick(r_s_p1, r_t_p1, r_idx_p1[2*i +: 2], r_sel_p1[i]),
                            r_neg_p1[i]);
`else
            w_res_p1[i*LANE_W +: LANE_W] =
                f_lane_pick(r_s_p1, r_t_p1, r_idx_p1[2*i +: 2], r_sel_p1[i]);
`endif
        end
    end

    // ---- stage 1 -> 2 : result register ----
    always_ff @(posedge clock) begin
        if (reset) begin
            r_vld_p2 <= 1'b0;
            r_out_p2 <= '0;
        end else if (w_adv) begin
            r_vld_p2 <= r_vld_p1;
            // On a bubble the last result stays visible for forwarding.
            if (r_vld_p1) begin
                r_out_p2 <= w_res_p1;
            end
        end
    end

    assign bus.regOut   = r_out_p2;
    assign bus.outValid = r_vld_p2;

endmodule
